pb_debounce_multi: RTL and testbench

Parametrised N-channel push-button/switch conditioner for the basic-IO Wishbone peripheral. Each channel has a configurable-depth synchroniser, a per-channel settle counter, selectable input polarity, press/release strobes, sticky press flags for software polling, and an optional hold-to-repeat strobe. It sits between the raw board pins and the basic-IO register file. Every channel is identical and independent.

---
 rtl/pb_debounce_multi_if.sv | 40 ++++
 rtl/pb_debounce_multi.sv | 123 ++++++++++++
 tb/tb_pb_debounce_multi.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pb_debounce_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : pb_debounce_multi_if
// Description : Pin-side bundle for the N-channel push-button conditioner.
//               The master drives the raw pins and the sticky-flag clears.
//               The slave (the conditioner) returns level, strobes and flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface pb_debounce_multi_if #(
  parameter int N = 4
);
  logic [N-1:0] pb_i;
  logic [N-1:0] evt_clr_i;
  logic [N-1:0] pb_state_o;
  logic [N-1:0] pb_down_o;
  logic [N-1:0] pb_up_o;
  logic [N-1:0] pb_rpt_o;
  logic [N-1:0] evt_o;

  modport master (
    output pb_i,
    output evt_clr_i,
    input  pb_state_o,
    input  pb_down_o,
    input  pb_up_o,
    input  pb_rpt_o,
    input  evt_o
  );

  modport slave (
    input  pb_i,
    input  evt_clr_i,
    output pb_state_o,
    output pb_down_o,
    output pb_up_o,
    output pb_rpt_o,
    output evt_o
  );
endinterface
`default_nettype wire

// File: rtl/pb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : pb_debounce_multi
// Description : N independent push-button/switch conditioners. Each channel
//               has a synchroniser, a settle counter, press/release strobes,
//               a sticky press flag and an optional hold-to-repeat strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module pb_debounce_multi #(
  parameter int N           = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int REPEAT_EN   = 0,
  parameter int RPT_W       = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  pb_debounce_multi_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [N-1:0]             w_act;
  logic [N-1:0]             w_sync;
  logic [N-1:0]             w_term;
  logic [N-1:0]             w_rise;
  logic [N-1:0]             w_fall;
  logic [N-1:0]             w_rpt;

  logic [SYNC_STAGES-1:0]   r_sync [N];
  logic [CNT_W-1:0]         r_cnt  [N];
  logic [N-1:0]             r_state;
  logic [N-1:0]             r_down;
  logic [N-1:0]             r_up;
  logic [N-1:0]             r_evt;

  // Normalise polarity and decode the terminal-count toggle per channel.
  always_comb begin
    w_act  = (ACTIVE_LOW != 0) ? ~bus.pb_i : bus.pb_i;
    w_sync = '0;
    w_term = '0;
    for (int i = 0; i < N; i++) begin
      w_sync[i] = r_sync[i][SYNC_STAGES-1];
      w_term[i] = (w_sync[i] != r_state[i]) && (&r_cnt[i]);
    end
    w_rise = w_term & ~r_state;
    w_fall = w_term &  r_state;
  end

  // Synchroniser chains; the newest sample enters at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_sync[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_act[i]};
    end
  end

  // Settle counters: cleared while idle, otherwise count and wrap at the
  // terminal value (which is also the toggle edge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_sync[i] == r_state[i]) r_cnt[i] <= '0;
        else                         r_cnt[i] <= r_cnt[i] + c_cnt_one;
      end
    end
  end

  // Debounced level, edge strobes and sticky press flags (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_down  <= '0;
      r_up    <= '0;
      r_evt   <= '0;
    end else begin
      r_state <= r_state ^ w_term;
      r_down  <= w_rise;
      r_up    <= w_fall;
      r_evt   <= w_rise | (r_evt & ~bus.evt_clr_i);
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_rpt_on
      localparam logic [RPT_W-1:0] c_rpt_one = {{(RPT_W-1){1'b0}}, 1'b1};
      logic [RPT_W-1:0] r_rcnt [N];
      logic [N-1:0]     r_rpt;

      // Repeat timers run only while held; the release edge clears the timer
      // and suppresses any wrap that lands on the same edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < N; i++) r_rcnt[i] <= '0;
          r_rpt <= '0;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (!r_state[i] || w_fall[i]) r_rcnt[i] <= '0;
            else                          r_rcnt[i] <= r_rcnt[i] + c_rpt_one;
            r_rpt[i] <= r_state[i] & ~w_fall[i] & (&r_rcnt[i]);
          end
        end
      end

      assign w_rpt = r_rpt;
    end else begin : g_rpt_off
      assign w_rpt = '0;
    end
  endgenerate

  assign bus.pb_state_o = r_state;
  assign bus.pb_down_o  = r_down;
  assign bus.pb_up_o    = r_up;
  assign bus.pb_rpt_o   = w_rpt;
  assign bus.evt_o      = r_evt;

endmodule
`default_nettype wire

// File: tb/tb_pb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pb_debounce_multi
// Description : Directed bench for pb_debounce_multi (N=4, CNT_W=3, two sync
//               stages, active-low pins, repeat enabled with RPT_W=4).
//               Expected strobe events are queued with their edge number and
//               a monitor matches them against what the design emits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_debounce_multi;

  typedef struct {
    int         cyc;
    logic [3:0] down;
    logic [3:0] up;
    logic [3:0] rpt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   c;
  exp_t q[$];
  exp_t mon_e;

  pb_debounce_multi_if #(.N(4)) bus ();

  pb_debounce_multi #(
    .N           (4),
    .CNT_W       (3),
    .SYNC_STAGES (2),
    .ACTIVE_LOW  (1),
    .REPEAT_EN   (1),
    .RPT_W       (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after posedge k, cyc == k.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_evt(input int at, input logic [3:0] d, input logic [3:0] u,
                            input logic [3:0] r);
    exp_t e;
    e.cyc  = at;
    e.down = d;
    e.up   = u;
    e.rpt  = r;
    q.push_back(e);
  endtask

  // Monitor: every cycle with any strobe must match the head of the queue.
  always @(negedge clk) begin
    if ((bus.pb_down_o | bus.pb_up_o | bus.pb_rpt_o) != 4'b0000) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got down=%b up=%b rpt=%b at edge %0d, expected none",
                 bus.pb_down_o, bus.pb_up_o, bus.pb_rpt_o, cyc);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.cyc != cyc || mon_e.down !== bus.pb_down_o ||
            mon_e.up !== bus.pb_up_o || mon_e.rpt !== bus.pb_rpt_o) begin
          n_fail++;
          $display("FAIL strobe_event: got edge %0d down=%b up=%b rpt=%b, expected edge %0d down=%b up=%b rpt=%b",
                   cyc, bus.pb_down_o, bus.pb_up_o, bus.pb_rpt_o,
                   mon_e.cyc, mon_e.down, mon_e.up, mon_e.rpt);
        end
      end
    end
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.pb_i      = 4'b1111;
    bus.evt_clr_i = 4'b0000;

    // Reset with all pins released, then run idle for 50 cycles.
    tick(3);
    check("reset_outputs",
          {16'h0, bus.pb_state_o, bus.pb_down_o, bus.pb_up_o, bus.evt_o}, 32'h0);
    rst_n = 1'b1;
    tick(50);
    check("idle_state", {28'h0, bus.pb_state_o}, 32'h0);
    check("idle_evt",   {28'h0, bus.evt_o},      32'h0);

    // Clean press and release on channel 0.
    c = cyc;
    bus.pb_i[0] = 1'b0;
    expect_evt(c + 10, 4'b0001, 4'b0000, 4'b0000);
    tick(12);
    check("ch0_pressed", {31'h0, bus.pb_state_o[0]}, 32'h1);
    check("ch0_evt_set", {31'h0, bus.evt_o[0]},      32'h1);
    bus.pb_i[0] = 1'b1;
    expect_evt(cyc + 10, 4'b0000, 4'b0001, 4'b0000);
    tick(12);
    check("ch0_released", {28'h0, bus.pb_state_o}, 32'h0);

    // Sticky clear takes effect on the next edge.
    bus.evt_clr_i[0] = 1'b1;
    tick(1);
    bus.evt_clr_i[0] = 1'b0;
    check("ch0_evt_clear", {31'h0, bus.evt_o[0]}, 32'h0);

    // 7-cycle glitch on channel 1 is rejected.
    bus.pb_i[1] = 1'b0;
    tick(7);
    bus.pb_i[1] = 1'b1;
    tick(20);
    check("ch1_glitch", {31'h0, bus.pb_state_o[1]}, 32'h0);

    // Bounce on channel 2, then settle pressed.
    for (int i = 0; i < 20; i++) begin
      bus.pb_i[2] = i[0];
      tick(1);
    end
    bus.pb_i[2] = 1'b0;
    c = cyc;
    expect_evt(c + 10, 4'b0100, 4'b0000, 4'b0000);
    tick(12);
    check("ch2_pressed",   {31'h0, bus.pb_state_o[2]},          32'h1);
    check("ch2_isolation", {28'h0, bus.pb_state_o & 4'b1011},   32'h0);
    bus.pb_i[2] = 1'b1;
    expect_evt(cyc + 10, 4'b0000, 4'b0100, 4'b0000);
    tick(12);

    // Clear on the same edge as a new press: set wins.
    c = cyc;
    bus.pb_i[0] = 1'b0;
    expect_evt(c + 10, 4'b0001, 4'b0000, 4'b0000);
    tick(9);
    bus.evt_clr_i[0] = 1'b1;
    tick(1);
    bus.evt_clr_i[0] = 1'b0;
    check("ch0_set_beats_clear", {31'h0, bus.evt_o[0]}, 32'h1);
    tick(2);
    bus.pb_i[0] = 1'b1;
    expect_evt(cyc + 10, 4'b0000, 4'b0001, 4'b0000);
    tick(12);

    // Hold channel 3: repeats at +16 and +32 after the press, release timed
    // to land on the third wrap edge, which must not repeat.
    c = cyc;
    bus.pb_i[3] = 1'b0;
    expect_evt(c + 10, 4'b1000, 4'b0000, 4'b0000);
    expect_evt(c + 26, 4'b0000, 4'b0000, 4'b1000);
    expect_evt(c + 42, 4'b0000, 4'b0000, 4'b1000);
    expect_evt(c + 58, 4'b0000, 4'b1000, 4'b0000);
    tick(48);
    bus.pb_i[3] = 1'b1;
    tick(40);
    check("ch3_released", {31'h0, bus.pb_state_o[3]}, 32'h0);

    // Asynchronous reset mid-hold, then the held button reads as a fresh press.
    c = cyc;
    bus.pb_i[1] = 1'b0;
    expect_evt(c + 10, 4'b0010, 4'b0000, 4'b0000);
    tick(13);
    check("pre_reset_state", {31'h0, bus.pb_state_o[1]}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_levels", {24'h0, bus.pb_state_o, bus.evt_o}, 32'h0);
    check("async_reset_strobes",
          {20'h0, bus.pb_down_o, bus.pb_up_o, bus.pb_rpt_o}, 32'h0);
    tick(3);
    rst_n = 1'b1;
    expect_evt(cyc + 10, 4'b0010, 4'b0000, 4'b0000);
    tick(12);
    bus.pb_i[1] = 1'b1;
    expect_evt(cyc + 10, 4'b0000, 4'b0010, 4'b0000);
    tick(14);

    check("all_events_seen", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
